// File: rtl/regfile_wb_scheduler_if.sv
// rtl/regfile_wb_scheduler_if.sv - issue/write-back/register-file signal bundle for the write-back scheduler
interface regfile_wb_scheduler_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
);
  // Reservation from issue
  logic                    rsv_valid;
  logic [ADDR_WIDTH-1:0]   rsv_reg;
  logic                    rsv_ready;
  // Producer write-back requests (index 0 = ALU, 1 = load/mul-div)
  logic [1:0]              req_valid;
  logic [2*ADDR_WIDTH-1:0] req_reg;
  logic [2*DATA_WIDTH-1:0] req_data;
  logic [1:0]              req_ready;
  // Register file write port
  logic                    rf_we;
  logic [ADDR_WIDTH-1:0]   rf_waddr;
  logic [DATA_WIDTH-1:0]   rf_wdata;
  // Operand hazard check and status
  logic [ADDR_WIDTH-1:0]   chk_reg_a;
  logic [ADDR_WIDTH-1:0]   chk_reg_b;
  logic                    chk_busy_a;
  logic                    chk_busy_b;
  logic [ADDR_WIDTH:0]     pending_cnt;
  logic                    err_unrsv;

  modport master (
    output rsv_valid, rsv_reg, req_valid, req_reg, req_data, chk_reg_a, chk_reg_b,
    input  rsv_ready, req_ready, rf_we, rf_waddr, rf_wdata, chk_busy_a, chk_busy_b,
           pending_cnt, err_unrsv
  );

  modport slave (
    input  rsv_valid, rsv_reg, req_valid, req_reg, req_data, chk_reg_a, chk_reg_b,
    output rsv_ready, req_ready, rf_we, rf_waddr, rf_wdata, chk_busy_a, chk_busy_b,
           pending_cnt, err_unrsv
  );
endinterface

// File: rtl/regfile_wb_scheduler.sv
// rtl/regfile_wb_scheduler.sv - round-robin write-back arbiter with per-register pending scoreboard
module regfile_wb_scheduler #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input logic                   clk,
  input logic                   reset,
  regfile_wb_scheduler_if.slave bus
);

  localparam int NREG = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] CNT_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

  logic [NREG-1:0]       pending;
  logic                  rrPtr;
  logic [1:0]            grant;
  logic                  gntIdx;
  logic                  accept;
  logic [ADDR_WIDTH-1:0] accReg;
  logic [DATA_WIDTH-1:0] accData;
  logic                  accWrites;
  logic                  rsvSet;
  logic                  wbClr;

  logic                  rfWe;
  logic [ADDR_WIDTH-1:0] rfWaddr;
  logic [DATA_WIDTH-1:0] rfWdata;
  logic [ADDR_WIDTH:0]   pendingCnt;
  logic                  errUnrsv;

  // Reservation is judged on the current pending state, so a register being cleared this
  // cycle still looks busy and the issue stage simply retries.
  assign bus.rsv_ready = bus.rsv_valid && ((bus.rsv_reg == '0) || !pending[bus.rsv_reg]);
  assign rsvSet        = bus.rsv_ready && (bus.rsv_reg != '0);

  // Round-robin grant: depends only on req_valid and the pointer, never on rf_* state.
  always_comb begin
    grant = 2'b00;
    case (bus.req_valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = rrPtr ? 2'b10 : 2'b01;
      default: grant = 2'b00;
    endcase
  end

  assign bus.req_ready = grant;
  assign gntIdx        = grant[1];
  assign accept        = |grant;
  assign accReg        = gntIdx ? bus.req_reg[2*ADDR_WIDTH-1:ADDR_WIDTH]
                                : bus.req_reg[ADDR_WIDTH-1:0];
  assign accData       = gntIdx ? bus.req_data[2*DATA_WIDTH-1:DATA_WIDTH]
                                : bus.req_data[DATA_WIDTH-1:0];
  // Writes to register 0 are granted but never reach the register file.
  assign accWrites     = accept && (accReg != '0);

  // A clear can only coincide with a set of a different register: a pending register
  // refuses reservation, so the two never target the same bit.
  assign wbClr = rfWe && pending[rfWaddr];

  // Arbitration pointer: favour the other producer after every grant.
  always_ff @(posedge clk) begin
    if (reset) begin
      rrPtr <= 1'b0;
    end else if (accept) begin
      rrPtr <= ~gntIdx;
    end
  end

  // Registered write port; a single-cycle rf_we pulse per accepted nonzero write.
  always_ff @(posedge clk) begin
    if (reset) begin
      rfWe    <= 1'b0;
      rfWaddr <= '0;
      rfWdata <= '0;
    end else begin
      rfWe <= accWrites;
      if (accWrites) begin
        rfWaddr <= accReg;
        rfWdata <= accData;
      end
    end
  end

  // Pending scoreboard, its population count and the sticky unreserved-write flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      pending    <= '0;
      pendingCnt <= '0;
      errUnrsv   <= 1'b0;
    end else begin
      if (wbClr) begin
        pending[rfWaddr] <= 1'b0;
      end
      if (rsvSet) begin
        pending[bus.rsv_reg] <= 1'b1;
      end
      case ({rsvSet, wbClr})
        2'b10:   pendingCnt <= pendingCnt + CNT_ONE;
        2'b01:   pendingCnt <= pendingCnt - CNT_ONE;
        default: pendingCnt <= pendingCnt;
      endcase
      if (accWrites && !pending[accReg]) begin
        errUnrsv <= 1'b1;
      end
    end
  end

  assign bus.rf_we       = rfWe;
  assign bus.rf_waddr    = rfWaddr;
  assign bus.rf_wdata    = rfWdata;
  assign bus.pending_cnt = pendingCnt;
  assign bus.err_unrsv   = errUnrsv;
  assign bus.chk_busy_a  = (bus.chk_reg_a != '0) && pending[bus.chk_reg_a];
  assign bus.chk_busy_b  = (bus.chk_reg_b != '0) && pending[bus.chk_reg_b];

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// tb/tb_regfile_wb_scheduler.sv - scoreboard bench for the write-back scheduler
module tb_regfile_wb_scheduler;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  regfile_wb_scheduler_if bus ();

  regfile_wb_scheduler dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
  } wb_t;

  wb_t         expQ[$];
  wb_t         monEntry;
  int          testCnt = 0;
  int          failCnt = 0;
  logic [31:0] pendM;
  bit          errM;
  bit          rrM;
  bit          prevWe;
  logic [4:0]  prevReg;
  logic [4:0]  ca;
  logic [4:0]  cb;

  task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    testCnt++;
    if (obs !== exp) begin
      failCnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] expGrant(input logic [1:0] v, input bit p);
    case (v)
      2'b01:   return 2'b01;
      2'b10:   return 2'b10;
      2'b11:   return p ? 2'b10 : 2'b01;
      default: return 2'b00;
    endcase
  endfunction

  task automatic checkState();
    checkVal("rf_we", {63'd0, bus.rf_we}, {63'd0, prevWe});
    checkVal("pending_cnt", {58'd0, bus.pending_cnt}, 64'($countones(pendM)));
    checkVal("err_unrsv", {63'd0, bus.err_unrsv}, {63'd0, errM});
  endtask

  // One clock cycle of stimulus; checks combinational outputs mid-cycle and state after the edge.
  task automatic drive(input bit rv, input logic [4:0] rr, input logic [1:0] qv,
                       input logic [4:0] r0, input logic [4:0] r1,
                       input logic [31:0] d0, input logic [31:0] d1);
    logic [1:0]  g;
    logic [4:0]  aReg;
    logic [31:0] aData;
    logic [31:0] nextP;
    bit          rsvOk;
    wb_t         e;
    reset         = 1'b0;
    bus.rsv_valid = rv;
    bus.rsv_reg   = rr;
    bus.req_valid = qv;
    bus.req_reg   = {r1, r0};
    bus.req_data  = {d1, d0};
    bus.chk_reg_a = ca;
    bus.chk_reg_b = cb;
    #1;
    rsvOk = rv && ((rr == 5'd0) || !pendM[rr]);
    g     = expGrant(qv, rrM);
    checkVal("rsv_ready", {63'd0, bus.rsv_ready}, {63'd0, rsvOk});
    checkVal("req_ready", {62'd0, bus.req_ready}, {62'd0, g});
    checkVal("chk_busy_a", {63'd0, bus.chk_busy_a}, {63'd0, (ca != 5'd0) && pendM[ca]});
    checkVal("chk_busy_b", {63'd0, bus.chk_busy_b}, {63'd0, (cb != 5'd0) && pendM[cb]});
    nextP = pendM;
    if (prevWe) nextP[prevReg] = 1'b0;
    if (rsvOk && rr != 5'd0) nextP[rr] = 1'b1;
    prevWe = 1'b0;
    if (g != 2'b00) begin
      aReg  = g[1] ? r1 : r0;
      aData = g[1] ? d1 : d0;
      rrM   = ~g[1];
      if (aReg != 5'd0) begin
        if (!pendM[aReg]) errM = 1'b1;
        e.addr = aReg;
        e.data = aData;
        expQ.push_back(e);
        prevWe  = 1'b1;
        prevReg = aReg;
      end
    end
    @(posedge clk);
    #1;
    pendM = nextP;
    checkState();
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 2'b00, 5'd0, 5'd0, 32'd0, 32'd0);
  endtask

  task automatic doReset(input int n, input logic [1:0] qv);
    reset         = 1'b1;
    bus.rsv_valid = 1'b0;
    bus.req_valid = qv;
    bus.chk_reg_a = ca;
    bus.chk_reg_b = cb;
    repeat (n) begin
      @(posedge clk);
      #1;
      pendM  = '0;
      errM   = 1'b0;
      rrM    = 1'b0;
      prevWe = 1'b0;
      checkState();
      checkVal("req_ready_rst", {62'd0, bus.req_ready}, {62'd0, expGrant(qv, rrM)});
      checkVal("chk_busy_rst", {63'd0, bus.chk_busy_a}, 64'd0);
    end
  endtask

  // Every rf_we pulse must match the oldest expected write, in grant order.
  always @(negedge clk) begin
    if (bus.rf_we === 1'b1) begin
      checkVal("wb_expected", {63'd0, expQ.size() != 0}, 64'd1);
      if (expQ.size() != 0) begin
        monEntry = expQ.pop_front();
        checkVal("rf_waddr", {59'd0, bus.rf_waddr}, {59'd0, monEntry.addr});
        checkVal("rf_wdata", {32'd0, bus.rf_wdata}, {32'd0, monEntry.data});
      end
    end
  end

  initial begin
    pendM         = '0;
    errM          = 1'b0;
    rrM           = 1'b0;
    prevWe        = 1'b0;
    prevReg       = 5'd0;
    ca            = 5'd0;
    cb            = 5'd0;
    reset         = 1'b1;
    bus.rsv_valid = 1'b0;
    bus.rsv_reg   = 5'd0;
    bus.req_valid = 2'b11;
    bus.req_reg   = {5'd2, 5'd1};
    bus.req_data  = {32'hAAAA_0001, 32'hAAAA_0000};
    bus.chk_reg_a = 5'd0;
    bus.chk_reg_b = 5'd0;

    // Reset with both producers requesting
    doReset(2, 2'b11);

    // Reserve r5, write it through the ALU port, watch busy drop at N+2
    ca = 5'd5;
    drive(1'b1, 5'd5, 2'b00, 5'd0, 5'd0, 32'd0, 32'd0);
    drive(1'b0, 5'd0, 2'b01, 5'd5, 5'd0, 32'hDEAD_BEEF, 32'd0);
    idle();
    idle();

    // Alternating grants with r1..r4; r4 reserved while r1 is being written back
    doReset(1, 2'b00);
    ca = 5'd1;
    cb = 5'd4;
    drive(1'b1, 5'd1, 2'b00, 5'd0, 5'd0, 32'd0, 32'd0);
    drive(1'b1, 5'd2, 2'b00, 5'd0, 5'd0, 32'd0, 32'd0);
    drive(1'b1, 5'd3, 2'b00, 5'd0, 5'd0, 32'd0, 32'd0);
    drive(1'b0, 5'd0, 2'b11, 5'd1, 5'd2, 32'h1000_0001, 32'h2000_0002);
    drive(1'b1, 5'd4, 2'b11, 5'd3, 5'd2, 32'h1000_0003, 32'h2000_0002);
    drive(1'b0, 5'd0, 2'b11, 5'd3, 5'd4, 32'h1000_0003, 32'h2000_0004);
    drive(1'b0, 5'd0, 2'b11, 5'd6, 5'd4, 32'h1000_0006, 32'h2000_0004);
    idle();
    idle();

    // Double reservation of r7, and reservation colliding with its write-back
    ca = 5'd7;
    cb = 5'd0;
    drive(1'b1, 5'd7, 2'b00, 5'd0, 5'd0, 32'd0, 32'd0);
    drive(1'b1, 5'd7, 2'b00, 5'd0, 5'd0, 32'd0, 32'd0);
    drive(1'b0, 5'd0, 2'b01, 5'd7, 5'd0, 32'h7777_0001, 32'd0);
    drive(1'b1, 5'd7, 2'b00, 5'd0, 5'd0, 32'd0, 32'd0);
    drive(1'b1, 5'd7, 2'b00, 5'd0, 5'd0, 32'd0, 32'd0);
    drive(1'b0, 5'd0, 2'b01, 5'd7, 5'd0, 32'h7777_0002, 32'd0);
    idle();
    idle();

    // Register 0 write is discarded; unreserved r9 write raises a sticky error
    ca = 5'd9;
    drive(1'b0, 5'd0, 2'b10, 5'd0, 5'd0, 32'd0, 32'h1234_5678);
    idle();
    drive(1'b0, 5'd0, 2'b10, 5'd0, 5'd9, 32'd0, 32'h9999_0009);
    idle();
    idle();
    idle();

    // Reset in the cycle after an accepted write drops all pending state
    ca = 5'd3;
    cb = 5'd12;
    drive(1'b1, 5'd3, 2'b00, 5'd0, 5'd0, 32'd0, 32'd0);
    drive(1'b1, 5'd12, 2'b00, 5'd0, 5'd0, 32'd0, 32'd0);
    drive(1'b0, 5'd0, 2'b01, 5'd3, 5'd0, 32'h3333_0003, 32'd0);
    doReset(1, 2'b00);
    idle();
    idle();

    checkVal("scoreboard_drained", 64'(expQ.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", testCnt, failCnt);
    $finish;
  end

endmodule
